// File: rtl/pipe_pkg.sv
// pipe_pkg: shared slot record, select encodings and width helper for the hazard scoreboard.
package pipe_pkg;
    localparam int ADDR_MAX_W = 8;
    localparam logic [ADDR_MAX_W-1:0] REG_ZERO = '0;
    localparam int FWD_RF = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;
    typedef struct packed {
        logic                  valid;
        logic [ADDR_MAX_W-1:0] rs;
        logic [ADDR_MAX_W-1:0] rt;
        logic [ADDR_MAX_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;
    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: matches one source register against every slot writer and picks the youngest allowed slot.
module hazard_src_match
    import pipe_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = 2
) (
    input  logic [ADDR_MAX_W-1:0] src,
    input  logic [N:0]            wr,
    input  logic [ADDR_MAX_W-1:0] rd [0:N],
    input  logic [N:0]            mask,
    output logic [N:0]            match,
    output logic [SEL_W-1:0]      sel
);
    // Walking oldest to youngest lets the youngest allowed slot win.
    always_comb begin
        match = '0;
        sel = SEL_W'(FWD_RF);
        for (int k = N; k >= 0; k--) begin
            match[k] = wr[k] && rd[k] == src && src != REG_ZERO;
            if (match[k] && mask[k]) sel = SEL_W'(k);
        end
    end
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: N-stage forwarding select and load-use/branch stall controller.
// Optional HAZARD_ID_FWD_EN adds ID-stage branch operand forwarding selects.
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LAT       = 1,
    localparam int SEL_W         = sel_width(NUM_FWD_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_branch,
    input  logic                  redirect,
    output logic [SEL_W-1:0]      a_sel,
    output logic [SEL_W-1:0]      b_sel,
`ifdef HAZARD_ID_FWD_EN
    output logic [SEL_W-1:0]      id_a_sel,
    output logic [SEL_W-1:0]      id_b_sel,
`endif
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  control_sel,
    output logic                  if_flush
);
    localparam int N = NUM_FWD_STAGES;

    slot_t                 s [0:N];
    logic [N:0]            wr, ld, ld_mask, br_mask, id_mask;
    logic [N:0]            m_xa, m_xb, m_ia, m_ib;
    logic [ADDR_MAX_W-1:0] rd [0:N];
    logic [SEL_W-1:0]      ida, idb;
    logic                  load_use, branch_haz;

    always_comb begin
        for (int j = 0; j <= N; j++) begin
            wr[j] = s[j].valid && s[j].reg_write;
            ld[j] = s[j].mem_read;
            rd[j] = s[j].rd;
            ld_mask[j] = ld[j] && j < LOAD_LAT;
`ifdef HAZARD_ID_FWD_EN
            br_mask[j] = j == 0 || (ld[j] && j <= LOAD_LAT);
            id_mask[j] = j > 0 && j < N && !(ld[j] && j <= LOAD_LAT);
`else
            br_mask[j] = j < N;
            id_mask[j] = 1'b0;
`endif
        end
    end

    hazard_src_match #(.N(N), .SEL_W(SEL_W)) u_xa (.src(s[0].rs), .wr(wr), .rd(rd), .mask(~(N+1)'(1)), .match(m_xa), .sel(a_sel));
    hazard_src_match #(.N(N), .SEL_W(SEL_W)) u_xb (.src(s[0].rt), .wr(wr), .rd(rd), .mask(~(N+1)'(1)), .match(m_xb), .sel(b_sel));
    hazard_src_match #(.N(N), .SEL_W(SEL_W)) u_ia (.src(ADDR_MAX_W'(id_rs)), .wr(wr), .rd(rd), .mask(id_mask), .match(m_ia), .sel(ida));
    hazard_src_match #(.N(N), .SEL_W(SEL_W)) u_ib (.src(ADDR_MAX_W'(id_rt)), .wr(wr), .rd(rd), .mask(id_mask), .match(m_ib), .sel(idb));

`ifdef HAZARD_ID_FWD_EN
    assign id_a_sel = ida;
    assign id_b_sel = idb;
`endif

    assign load_use    = (id_uses_rs && |(m_ia & ld_mask)) || (id_uses_rt && |(m_ib & ld_mask));
    assign branch_haz  = id_branch && ((id_uses_rs && |(m_ia & br_mask)) || (id_uses_rt && |(m_ib & br_mask)));
    assign stall       = load_use || branch_haz;
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign control_sel = ~stall;
    assign if_flush    = redirect && !stall;

    // A stalled cycle sends a bubble into EX while IF/ID holds the instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= N; k++) s[k] <= '0;
        end else begin
            s[0] <= stall ? '0 : slot_t'{valid: 1'b1, rs: ADDR_MAX_W'(id_rs), rt: ADDR_MAX_W'(id_rt),
                                         rd: ADDR_MAX_W'(id_rd), reg_write: id_reg_write, mem_read: id_mem_read};
            for (int k = 1; k <= N; k++) s[k] <= s[k-1];
        end
    end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed forwarding, load-use, branch and async-reset scenarios with default parameters.
module tb_pipe_hazard_scoreboard;
    logic       clk = 1'b0, rst = 1'b1;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_branch, redirect;
    logic [1:0] a_sel, b_sel;
`ifdef HAZARD_ID_FWD_EN
    logic [1:0] id_a_sel, id_b_sel;
`endif
    logic       stall, pc_write, ifid_write, control_sel, if_flush;
    int         vecs = 0, errs = 0;

    pipe_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_branch(id_branch), .redirect(redirect),
        .a_sel(a_sel), .b_sel(b_sel),
`ifdef HAZARD_ID_FWD_EN
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
`endif
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
        .control_sel(control_sel), .if_flush(if_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic br);
        id_rs = rs; id_rt = rt; id_uses_rs = ur; id_uses_rt = ut;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_branch = br;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        id(0, 0, 0, 0, 0, 0, 0, 0);
        redirect = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_a_sel", a_sel, 0);
        chk("rst_b_sel", b_sel, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_control_sel", control_sel, 1);
        chk("rst_if_flush", if_flush, 1);
        redirect = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // add $3 ; sub $8,$3,$7 back to back, then with one gap
        id(0, 0, 0, 0, 3, 1, 0, 0); cyc();
        id(3, 7, 1, 1, 8, 1, 0, 0); #1;
        chk("fwd1_stall", stall, 0);
        cyc();
        chk("fwd1_a_sel", a_sel, 1);
        chk("fwd1_b_sel", b_sel, 0);
        id(0, 0, 0, 0, 3, 1, 0, 0); cyc();
        id(0, 0, 0, 0, 0, 0, 0, 0); cyc();
        id(3, 7, 1, 1, 9, 1, 0, 0); #1;
        chk("fwd2_stall", stall, 0);
        cyc();
        chk("fwd2_a_sel", a_sel, 2);
        // lw $4 ; add $5,$4,$4
        id(1, 0, 1, 0, 4, 1, 1, 0); cyc();
        id(4, 4, 1, 1, 5, 1, 0, 0); #1;
        chk("lu_stall", stall, 1);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_control_sel", control_sel, 0);
        cyc(); #1;
        chk("lu_stall_end", stall, 0);
        chk("lu_pc_write_end", pc_write, 1);
        cyc();
        chk("lu_a_sel", a_sel, 2);
        chk("lu_b_sel", b_sel, 2);
        // two producers of $3: youngest wins
        id(0, 0, 0, 0, 3, 1, 0, 0); cyc();
        id(1, 1, 1, 1, 3, 1, 0, 0); cyc();
        id(3, 0, 1, 0, 10, 1, 0, 0); #1;
        chk("young_stall", stall, 0);
        cyc();
        chk("young_a_sel", a_sel, 1);
        // writes to $0 never match
        id(0, 0, 0, 0, 0, 1, 1, 0); cyc();
        id(0, 0, 1, 1, 11, 1, 0, 0); #1;
        chk("zero_ld_stall", stall, 0);
        cyc();
        chk("zero_ld_a_sel", a_sel, 0);
        chk("zero_ld_b_sel", b_sel, 0);
        id(0, 0, 0, 0, 0, 1, 0, 0); cyc();
        id(0, 0, 1, 1, 12, 1, 0, 0); cyc();
        chk("zero_alu_a_sel", a_sel, 0);
        // add $6 ; beq $6,$7 with a simultaneous redirect
        id(0, 0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
        id(0, 0, 0, 0, 6, 1, 0, 0); cyc();
        id(6, 7, 1, 1, 0, 0, 0, 1);
        redirect = 1'b1; #1;
        chk("br_stall0", stall, 1);
        chk("br_flush0", if_flush, 0);
        chk("br_pc_write0", pc_write, 0);
        cyc(); #1;
`ifdef HAZARD_ID_FWD_EN
        chk("br_stall1", stall, 0);
        chk("br_id_a_sel", id_a_sel, 1);
        chk("br_id_b_sel", id_b_sel, 0);
        chk("br_flush1", if_flush, 1);
`else
        chk("br_stall1", stall, 1);
        chk("br_flush1", if_flush, 0);
        cyc(); #1;
        chk("br_stall2", stall, 0);
        chk("br_flush2", if_flush, 1);
`endif
        redirect = 1'b0;
        id(0, 0, 0, 0, 0, 0, 0, 0); cyc();
        // async reset in the middle of a load-use stall
        id(0, 0, 0, 0, 3, 1, 0, 0); cyc();
        id(3, 0, 1, 0, 4, 1, 1, 0); #1;
        chk("pre_rst_nostall", stall, 0);
        cyc();
        id(4, 4, 1, 1, 5, 1, 0, 0); #1;
        chk("pre_rst_stall", stall, 1);
        chk("pre_rst_a_sel", a_sel, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_a_sel", a_sel, 0);
        chk("arst_b_sel", b_sel, 0);
        chk("arst_pc_write", pc_write, 1);
        @(negedge clk);
        rst = 1'b0;
        id(1, 0, 1, 0, 4, 1, 1, 0); #1;
        chk("post_rst_lw", stall, 0);
        cyc();
        id(4, 4, 1, 1, 5, 1, 0, 0); #1;
        chk("post_rst_stall", stall, 1);
        cyc(); #1;
        chk("post_rst_stall_end", stall, 0);
        cyc();
        chk("post_rst_a_sel", a_sel, 2);
        chk("post_rst_b_sel", b_sel, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
Parametrised hazard-detection and forwarding controller for the pipelined MIPS core. It tracks destination registers of in-flight instructions across a configurable number of post-ID stages. It drives the EX-stage operand forwarding selects and the stall/flush controls for PC, IF/ID and the control-signal bubble mux. It generalises the fixed two-source, two-stage scheme to N forwarding stages, configurable load latency, and ID-stage branch operand hazards.

Parameters:
REG_ADDR_W, 5, register address width
NUM_FWD_STAGES, 2, post-EX stages able to forward (slot 1 = EX/MEM, slot 2 = MEM/WB, ...); at least 1
LOAD_LAT, 1, extra cycles after EX/MEM before load data is forwardable; range 0 to NUM_FWD_STAGES-1
SEL_W, $clog2(NUM_FWD_STAGES+1), forwarding select width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_rs  in  REG_ADDR_W  ID source 1
id_rt  in  REG_ADDR_W  ID source 2
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_rd  in  REG_ADDR_W  ID destination, after regDst selection
id_reg_write  in  1  ID instruction writes a register
id_mem_read  in  1  ID instruction is a load
id_branch  in  1  ID instruction compares operands in ID
redirect  in  1  taken branch or jump resolved in ID
a_sel  out  SEL_W  EX operand A select; 0 = register file, k = slot k
b_sel  out  SEL_W  EX operand B select, same encoding
stall  out  1  hazard stall
pc_write  out  1  equals ~stall
ifid_write  out  1  equals ~stall
control_sel  out  1  0 inserts a bubble into ID/EX; equals ~stall
if_flush  out  1  equals redirect & ~stall

Behaviour:
- State: slot 0 holds the instruction in EX {valid, rs, rt, rd, reg_write, mem_read}. Slots 1..NUM_FWD_STAGES hold the older instructions {valid, rd, reg_write, mem_read}.
- Every cycle, slot k shifts to slot k+1 and the oldest slot is dropped.
- Slot 0 loading:
  - not stall: slot 0 loads the ID fields with valid=1.
  - stall: slot 0 loads a bubble (valid=0), and IF/ID holds.
- Reset (async, any time): all slots invalid. Outputs: a_sel=b_sel=0, stall=0, pc_write=ifid_write=control_sel=1, if_flush=redirect.
- Writer(k, r): slot k valid, reg_write=1, rd==r, and r!=0.
- Register 0 never matches.
- a_sel is the smallest k in 1..NUM_FWD_STAGES with writer(k, slot0.rs); 0 if none. b_sel is the same for slot0.rt. The youngest producer wins.
- a_sel and b_sel are combinational from registered state; there is no added latency.
- Load-use stall: an ID source in use matches writer(j) with mem_read=1, for j in 0..LOAD_LAT-1.
  - With defaults: load in EX plus dependent in ID gives exactly 1 stall cycle.
- Branch stall (id_branch=1): an ID source in use matches writer(j), for j in 0..NUM_FWD_STAGES-1.
  - Slot NUM_FWD_STAGES writes the register file with write-before-read, so it never stalls.
- stall = load-use stall OR branch stall.
- Stall overrides redirect: if_flush=0 while stalled, and the branch is re-evaluated next cycle.
- Back-to-back hazards: the stall repeats until the producer reaches a ready slot. A bubble entering slot 0 never creates a hazard.

Optional Feature:
Macro: HAZARD_ID_FWD_EN.
- Defined:
  - Adds outputs id_a_sel and id_b_sel (SEL_W bits each). Each is the smallest k in 1..NUM_FWD_STAGES-1 with writer(k) of the ID source and not a pending load. Encoding 0 = register file.
  - The branch stall is reduced to: a writer in slot 0, or a load writer in slots 0..LOAD_LAT.
- Undefined: the ports are absent and the branch stall is as described in Behaviour.

Decomposition:
- Package pipe_pkg holds:
  - the slot_t struct {valid, rs, rt, rd, reg_write, mem_read}
  - the REG_ZERO constant
  - the sel-width function
  - the select encoding constants FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2
- Sub-module hazard_src_match compares one source register against all slots. It returns a per-slot match vector and a priority-encoded youngest index. It is instantiated once per source (EX rs, EX rt, ID rs, ID rt).

Test Plan:
- add $3 then sub using $3 in the next cycle -> a_sel=1 in sub's EX cycle; with one instruction between them -> a_sel=2; stall stays 0.
- lw $4 then add $5,$4,$4 -> stall=1 for exactly 1 cycle, with pc_write=0 and control_sel=0; then a_sel=b_sel=2.
- add $3, add $3, then use $3 -> a_sel=1, the youngest producer, not 2.
- addi $0 followed by a use of $0 -> a_sel=0 and no stall.
- add $6 then beq $6 -> stall asserted while $6 is in slots 0..1 (2 cycles); with HAZARD_ID_FWD_EN, 1 cycle then id_a_sel=1. A simultaneous redirect during the stall -> if_flush=0.
- rst pulsed mid-stall, asynchronously -> stall=0 and all selects 0 immediately; after release, a load-use pair behaves as in the second scenario.
